// File: rtl/vram_frame_loader_if.sv
// Byte-stream input and VRAM write port of the frame loader.
// master = loader side, slave = source/VRAM side.
interface vram_frame_loader_if #(
    parameter int AW = 18
);
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [11:0]   wdata;

    modport master (input in_data, in_valid, output in_ready, we, waddr, wdata);
    modport slave  (output in_data, in_valid, input in_ready, we, waddr, wdata);
endinterface

// File: rtl/vram_frame_loader.sv
// Streams 2-byte RGB444 pixels into VRAM, FRAME_COUNT frames of FRAME_SIZE pixels
// laid out back to back from address 0.
module vram_frame_loader #(
    parameter int FRAME_COUNT = 5,
    parameter int FRAME_SIZE  = 30000,
    parameter int AW          = 18
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic                    abort,
    vram_frame_loader_if.master     bus,
    output logic                    busy,
    output logic                    done,
    output logic [3:0]              frames_loaded
);
    localparam int PW = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;

    typedef enum logic [1:0] {IDLE, BYTE0, BYTE1, DONE} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] pix_cnt;
    logic [AW-1:0] frame_base;
    logic [3:0]    red;
    logic          hs, last_pix, last_frame, restart;

    assign hs         = bus.in_valid && bus.in_ready;
    assign last_pix   = (pix_cnt == PW'(FRAME_SIZE - 1));
    assign last_frame = (frames_loaded == 4'(FRAME_COUNT - 1));
    assign restart    = start && (state == IDLE || state == DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        bus.in_ready = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE:  if (start) state_nx = BYTE0;
            BYTE0: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
                if (hs) state_nx = BYTE1;
            end
            BYTE1: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
                if (hs) state_nx = (last_pix && last_frame) ? DONE : BYTE0;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nx = BYTE0;
            end
            default: state_nx = IDLE;
        endcase
        // abort wins over start and over a same-cycle handshake
        if (abort) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pix_cnt       <= '0;
            frame_base    <= '0;
            frames_loaded <= '0;
            red           <= '0;
            bus.we        <= 1'b0;
            bus.waddr     <= '0;
            bus.wdata     <= '0;
        end else begin
            bus.we <= 1'b0;
            if (abort || restart) begin
                pix_cnt       <= '0;
                frame_base    <= '0;
                frames_loaded <= '0;
            end else if (hs && state == BYTE0) begin
                red <= bus.in_data[3:0];
            end else if (hs && state == BYTE1) begin
                bus.we    <= 1'b1;
                bus.waddr <= frame_base + AW'(pix_cnt);
                bus.wdata <= {red, bus.in_data};
                if (last_pix) begin
                    pix_cnt       <= '0;
                    frame_base    <= frame_base + AW'(FRAME_SIZE);
                    frames_loaded <= frames_loaded + 4'd1;
                end else begin
                    pix_cnt <= pix_cnt + PW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_vram_frame_loader.sv
// Random-gap pixel streams checked against a linear pixel-index model of the VRAM layout.
module tb_vram_frame_loader;
    localparam int FC = 5;
    localparam int FS = 24;
    localparam int AW = 18;

    logic       clk = 1'b0;
    logic       rstn, start, abort;
    logic       busy, done;
    logic [3:0] frames_loaded;

    vram_frame_loader_if #(.AW(AW)) bus ();

    vram_frame_loader #(.FRAME_COUNT(FC), .FRAME_SIZE(FS), .AW(AW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .bus(bus.master),
        .busy(busy), .done(done), .frames_loaded(frames_loaded)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int k = 0;            // pixels written since last start (model)
    int exp_we = 0, we_seen = 0;

    always @(posedge clk) begin
        #1;
        if (bus.we === 1'b1) we_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        rdy = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            bus.in_valid = 1'b0;
            cyc();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int t = 0; t < 20 && !rdy; t++) begin
            rdy = bus.in_ready;
            cyc();
        end
        bus.in_valid = 1'b0;
        if (!rdy) chk("hs_timeout", {31'd0, rdy}, 32'd1);
    endtask

    task automatic send_pix(input logic [3:0] hi, input logic [3:0] r, input logic [3:0] g,
                            input logic [3:0] b);
        send_byte({hi, r});
        send_byte({g, b});
        chk("we",    {31'd0, bus.we}, 32'd1);
        chk("waddr", 32'(bus.waddr), 32'(k));
        chk("wdata", 32'(bus.wdata), 32'({r, g, b}));
        chk("frames", 32'(frames_loaded), 32'((k + 1) / FS));
        chk("done",  {31'd0, done}, {31'd0, (k + 1) == FC * FS});
        k++;
        exp_we++;
    endtask

    task automatic rand_pix();
        send_pix(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        k = 0;
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; abort = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 8'h00;
        repeat (3) cyc();
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_we",       {31'd0, bus.we}, 32'd0);
        chk("rst_waddr",    32'(bus.waddr), 32'd0);
        chk("rst_wdata",    32'(bus.wdata), 32'd0);
        chk("rst_busy",     {31'd0, busy}, 32'd0);
        chk("rst_done",     {31'd0, done}, 32'd0);
        chk("rst_frames",   32'(frames_loaded), 32'd0);
        rstn = 1'b1;
        cyc();

        // single pixel, exact bytes 0x0A 0x5C
        do_start();
        chk("busy_start", {31'd0, busy}, 32'd1);
        send_pix(4'h0, 4'hA, 4'h5, 4'hC);
        cyc();
        chk("we_pulse_one", {31'd0, bus.we}, 32'd0);
        abort = 1'b1; cyc(); abort = 1'b0;

        // full load with a stray start mid-stream
        do_start();
        for (int i = 0; i < FC * FS; i++) begin
            if (i == 30) begin
                start = 1'b1; cyc(); start = 1'b0;
            end
            rand_pix();
        end
        chk("full_done",   {31'd0, done}, 32'd1);
        chk("full_frames", 32'(frames_loaded), FC);
        chk("full_rdy",    {31'd0, bus.in_ready}, 32'd0);
        chk("full_busy",   {31'd0, busy}, 32'd0);
        bus.in_valid = 1'b1; bus.in_data = 8'h3C;
        repeat (3) begin
            cyc();
            chk("done_hold",  {31'd0, done}, 32'd1);
            chk("done_nordy", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.in_valid = 1'b0;
        cyc();
        chk("we_count_full", 32'(we_seen), 32'(exp_we));

        // restart from DONE, abort at frame 2 pixel 10 with a byte1 handshake pending
        do_start();
        chk("restart_done",   {31'd0, done}, 32'd0);
        chk("restart_frames", 32'(frames_loaded), 32'd0);
        for (int i = 0; i < 2 * FS + 10; i++) rand_pix();
        send_byte(8'h07);
        bus.in_valid = 1'b1; bus.in_data = 8'hFF; abort = 1'b1;
        cyc();
        abort = 1'b0; bus.in_valid = 1'b0;
        chk("abort_we",     {31'd0, bus.we}, 32'd0);
        chk("abort_busy",   {31'd0, busy}, 32'd0);
        chk("abort_rdy",    {31'd0, bus.in_ready}, 32'd0);
        chk("abort_frames", 32'(frames_loaded), 32'd0);
        repeat (2) cyc();
        chk("we_count_abort", 32'(we_seen), 32'(exp_we));
        do_start();
        rand_pix();
        rand_pix();

        // start and abort together mid-load
        start = 1'b1; abort = 1'b1;
        cyc();
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", {31'd0, busy}, 32'd0);
        cyc();
        chk("sa_idle", {31'd0, bus.in_ready}, 32'd0);

        // reset during BYTE1
        do_start();
        repeat (3) rand_pix();
        send_byte(8'h09);
        bus.in_valid = 1'b1; bus.in_data = 8'hAB;
        #2 rstn = 1'b0;
        #1;
        chk("arst_rdy",    {31'd0, bus.in_ready}, 32'd0);
        chk("arst_busy",   {31'd0, busy}, 32'd0);
        chk("arst_waddr",  32'(bus.waddr), 32'd0);
        chk("arst_wdata",  32'(bus.wdata), 32'd0);
        chk("arst_frames", 32'(frames_loaded), 32'd0);
        chk("arst_we",     {31'd0, bus.we}, 32'd0);
        cyc();
        bus.in_valid = 1'b0;
        rstn = 1'b1;
        repeat (3) cyc();
        chk("we_count_rst", 32'(we_seen), 32'(exp_we));
        chk("rst_idle",     {31'd0, busy}, 32'd0);
        do_start();
        rand_pix();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vram_frame_loader.md
VRAM_FRAME_LOADER -- requirements
Module: vram_frame_loader

Interface
REQ-001 SHALL have parameter FRAME_COUNT, default 5: number of frames loaded per load operation.
REQ-002 SHALL have parameter FRAME_SIZE, default 30000: pixels per frame (200 x 150).
REQ-003 SHALL have parameter AW, default 18: VRAM write-address width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-005 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: single-cycle pulse that begins a load.
REQ-007 SHALL have port abort, input, 1 bit: single-cycle pulse that cancels a load.
REQ-008 SHALL have port in_data, input, 8 bits: incoming byte stream.
REQ-009 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-010 SHALL have port in_ready, output, 1 bit: loader accepts a byte.
REQ-011 SHALL have port we, output, 1 bit: VRAM write enable, one cycle per pixel.
REQ-012 SHALL have port waddr, output, AW bits: VRAM write address.
REQ-013 SHALL have port wdata, output, 12 bits: pixel data in {R[3:0], G[3:0], B[3:0]} order.
REQ-014 SHALL have port busy, output, 1 bit: a load is in progress.
REQ-015 SHALL have port done, output, 1 bit: all frames are written.
REQ-016 SHALL have port frames_loaded, output, 4 bits: count of completed frames.

Function
REQ-017 SHALL implement a state machine with states IDLE, BYTE0, BYTE1 and DONE.
REQ-018 SHALL complete a byte handshake only in a cycle where in_valid=1 and in_ready=1; any other cycle SHALL leave all state unchanged.
REQ-019 SHALL drive in_ready=1 exactly in BYTE0 and BYTE1, and 0 in IDLE and DONE.
REQ-020 SHALL, on start while in IDLE or DONE, go to BYTE0, clear the pixel counter, frame base and frames_loaded, and drop done.
REQ-021 SHALL ignore start while in BYTE0 or BYTE1.
REQ-022 SHALL, on a handshake in BYTE0, latch in_data[3:0] as red, ignore in_data[7:4], and go to BYTE1.
REQ-023 SHALL, on a handshake in BYTE1, latch in_data[7:4] as green and in_data[3:0] as blue, issue a pixel write, and go to BYTE0, or to DONE if this pixel was the last one.
REQ-024 SHALL register the write: we=1 in the cycle after the BYTE1 handshake, with waddr = frame_base + pix_cnt and wdata = {R,G,B} of that pixel; we SHALL be 0 in all other cycles.
REQ-025 SHALL add pix_cnt zero-extended to AW bits; frame_base steps by FRAME_SIZE, giving a maximum address of FRAME_COUNT*FRAME_SIZE-1 = 149999, which fits in 18 bits.
REQ-026 SHALL increment pix_cnt after each write, except at pix_cnt = FRAME_SIZE-1, where pix_cnt SHALL wrap to 0, frame_base SHALL increase by FRAME_SIZE, and frames_loaded SHALL increase by 1.
REQ-027 SHALL treat the last pixel as pix_cnt = FRAME_SIZE-1 while frames_loaded = FRAME_COUNT-1; that write SHALL enter DONE, so done=1 and frames_loaded=FRAME_COUNT in the same cycle as the final we=1.
REQ-028 SHALL hold done=1 in DONE until start or abort, and SHALL not accept bytes or issue writes while in DONE.
REQ-029 SHALL drive busy=1 exactly in BYTE0 and BYTE1.
REQ-030 SHALL, on abort in any state, go to IDLE next cycle, clear done, pix_cnt, frame_base and frames_loaded, and suppress the pending we.
REQ-031 SHALL give abort priority over start and over a byte handshake in the same cycle.
REQ-032 SHALL not depend on stalls: any number of idle cycles between bytes (in_valid=0) SHALL not change the state, address or latched data.

Reset
REQ-033 SHALL, on rstn=0, immediately and asynchronously force: state=IDLE, in_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, frames_loaded=0, pix_cnt=0, frame_base=0.
REQ-034 SHALL treat reset mid-load like abort: no further we until a new start after rstn releases.

Verification
REQ-035 SHALL verify single pixel: start, then bytes 0x0A, 0x5C -> one we pulse with waddr=0, wdata=0xA5C, one cycle after the second handshake.
REQ-036 SHALL verify frame boundary: after 30000 pixels, the next pixel writes waddr=30000 and frames_loaded reads 1.
REQ-037 SHALL verify a full load: 5x30000 pixels with random in_valid gaps -> the last we has waddr=149999, done=1 and frames_loaded=5 in that cycle, and in_ready=0 afterwards.
REQ-038 SHALL verify abort at frame 2, pixel 100 -> IDLE, no we, frames_loaded=0; a following start writes from waddr=0.
REQ-039 SHALL verify start pulsed mid-load is ignored (addresses continue), and start together with abort -> IDLE.
REQ-040 SHALL verify rstn asserted mid-BYTE1 -> all outputs 0 asynchronously, with no write issued for the half-received pixel.
